// File: rtl/axis_hdr_pkg.sv
// Shared types and default widths for the AXI-Stream header scheduler.
// Holds the scheduler state enum, default widths and the packet counter width.
package axis_hdr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAY,
    DRAIN
  } state_t;

  localparam int DATA_WD_DEF = 32;
  localparam int NUM_SRC_DEF = 4;
  localparam int PKT_CNT_WD  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the last grant + 1, wrapping.
// Ports: clk, rst, req vector, advance strobe, grant index, grant_valid.
module rr_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_WD  = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [SRC_WD-1:0]  grant,
  output logic               grant_valid
);

  logic [SRC_WD-1:0] ptr;
  logic [SRC_WD-1:0] idx;

  // Pointer holds the last winner; NUM_SRC-1 after reset so
  // the first search starts at source 0.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = SRC_WD'((int'(ptr) + i) % NUM_SRC);
      if (!grant_valid && req[idx]) begin
        grant       = idx;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= SRC_WD'(NUM_SRC - 1);
    end else if (advance && grant_valid) begin
      ptr <= grant;
    end
  end

endmodule

// File: rtl/axis_header_scheduler.sv
// Arbitrates header requesters, inserts the winning header, then gates
// the payload stream until the datapath emits the packet's last beat.
// Ports: req_* (header requests), *_insert (header to datapath),
// s_*_in / valid_in / ready_in (payload gate), *_out (datapath output
// monitor), grant_id, busy, pkt_cnt (status).
module axis_header_scheduler
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_SRC      = NUM_SRC_DEF,
  parameter int SRC_WD       = $clog2(NUM_SRC)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC-1:0]              req_valid,
  input  logic [NUM_SRC*DATA_WD-1:0]      req_data,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]  req_byte_cnt,
  output logic [NUM_SRC-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            s_valid_in,
  input  logic                            s_last_in,
  output logic                            s_ready_in,
  output logic                            valid_in,
  input  logic                            ready_in,
  input  logic                            last_out,
  input  logic                            valid_out,
  input  logic                            ready_out,
  output logic [SRC_WD-1:0]               grant_id,
  output logic                            busy,
  output logic [PKT_CNT_WD-1:0]           pkt_cnt
);

  state_t            state;
  state_t            state_nxt;
  logic              advance;
  logic              done;
  logic [SRC_WD-1:0] arb_grant;
  logic              arb_valid;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SRC_WD  (SRC_WD)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .advance     (advance),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  assign done = valid_out && ready_out && last_out;
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    advance      = 1'b0;
    valid_insert = 1'b0;
    valid_in     = 1'b0;
    s_ready_in   = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid) begin
          advance   = 1'b1;
          state_nxt = HDR;
        end
      end
      HDR: begin
        valid_insert = 1'b1;
        if (ready_insert) state_nxt = PAY;
      end
      PAY: begin
        valid_in   = s_valid_in;
        s_ready_in = ready_in;
        if (s_valid_in && ready_in && s_last_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Header mux and one-hot accept are decoded from the registered owner.
  always_comb begin
    data_insert     = '0;
    keep_insert     = '0;
    byte_insert_cnt = '0;
    req_ready       = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == SRC_WD'(i)) begin
        data_insert     = req_data[i*DATA_WD +: DATA_WD];
        keep_insert     = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
        byte_insert_cnt = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
        req_ready[i]    = (state == HDR) && ready_insert;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      pkt_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (advance) grant_id <= arb_grant;
      if (state == DRAIN && done) begin
        pkt_cnt <= pkt_cnt + PKT_CNT_WD'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_header_scheduler.sv
// Randomized self-checking bench for axis_header_scheduler.
// Transaction-level model: round-robin pick, packet count, phase checks.
module tb_axis_header_scheduler;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int NS = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NS-1:0]  req_valid;
  logic [NS*DW-1:0] req_data;
  logic [NS*BW-1:0] req_keep;
  logic [NS*CW-1:0] req_byte_cnt;
  logic [NS-1:0]  req_ready;
  logic           valid_insert;
  logic [DW-1:0]  data_insert;
  logic [BW-1:0]  keep_insert;
  logic [CW-1:0]  byte_insert_cnt;
  logic           ready_insert;
  logic           s_valid_in;
  logic           s_last_in;
  logic           s_ready_in;
  logic           valid_in;
  logic           ready_in;
  logic           last_out;
  logic           valid_out;
  logic           ready_out;
  logic [SW-1:0]  grant_id;
  logic           busy;
  logic [15:0]    pkt_cnt;

  logic [DW-1:0]  hdr_d [NS];
  logic [BW-1:0]  hdr_k [NS];
  logic [CW-1:0]  hdr_c [NS];

  int n_chk  = 0;
  int n_pass = 0;
  int last_g;
  int exp_cnt;

  always #5 clk = ~clk;

  always_comb begin
    req_data     = '0;
    req_keep     = '0;
    req_byte_cnt = '0;
    for (int i = 0; i < NS; i++) begin
      req_data[i*DW +: DW]     = hdr_d[i];
      req_keep[i*BW +: BW]     = hdr_k[i];
      req_byte_cnt[i*CW +: CW] = hdr_c[i];
    end
  end

  axis_header_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_byte_cnt    (req_byte_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .s_valid_in      (s_valid_in),
    .s_last_in       (s_last_in),
    .s_ready_in      (s_ready_in),
    .valid_in        (valid_in),
    .ready_in        (ready_in),
    .last_out        (last_out),
    .valid_out       (valid_out),
    .ready_out       (ready_out),
    .grant_id        (grant_id),
    .busy            (busy),
    .pkt_cnt         (pkt_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input int last, input logic [NS-1:0] m);
    int k;
    for (int i = 1; i <= NS; i++) begin
      k = (last + i) % NS;
      if (m[k[SW-1:0]]) return k;
    end
    return -1;
  endfunction

  task automatic quiet;
    req_valid    = '0;
    ready_insert = 1'b0;
    s_valid_in   = 1'b0;
    s_last_in    = 1'b0;
    ready_in     = 1'b0;
    last_out     = 1'b0;
    valid_out    = 1'b0;
    ready_out    = 1'b0;
  endtask

  task automatic do_reset;
    quiet();
    rst = 1'b1;
    ready_in = 1'b1;
    s_valid_in = 1'b1;
    tick();
    rst = 1'b0;
    last_g  = NS - 1;
    exp_cnt = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);
    check("rst_valid_insert", valid_insert, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_s_ready_in", s_ready_in, 0);
    check("rst_valid_in", valid_in, 0);
    quiet();
  endtask

  task automatic run_packet(input logic [NS-1:0] mask, input int nbeats,
                            input int stall, input bit rnd,
                            input bit abort, output int g);
    int src;
    logic [SW-1:0] sw;
    logic [NS-1:0] onehot;
    bit sv, rd, acc;
    if (rnd) begin
      for (int i = 0; i < NS; i++) begin
        hdr_d[i] = $urandom;
        hdr_k[i] = BW'($urandom);
        hdr_c[i] = CW'($urandom);
      end
    end
    src = rr_pick(last_g, mask);
    g   = src;
    sw  = SW'(src);
    onehot = '0;
    onehot[sw] = 1'b1;
    req_valid = mask;
    #1;
    check("no_comb_valid", valid_insert, 0);
    tick();
    check("hdr_valid", valid_insert, 1);
    check("grant_id", grant_id, src);
    check("data_insert", data_insert, hdr_d[sw]);
    check("keep_insert", keep_insert, hdr_k[sw]);
    check("byte_cnt", byte_insert_cnt, hdr_c[sw]);
    if (rnd && $urandom_range(0, 1) == 1) req_valid[sw] = 1'b0;
    s_valid_in = 1'b1;
    ready_in   = 1'b1;
    for (int c = 0; c < stall; c++) begin
      #1;
      check("stall_valid", valid_insert, 1);
      check("stall_data", data_insert, hdr_d[sw]);
      check("stall_s_ready", s_ready_in, 0);
      check("stall_valid_in", valid_in, 0);
      check("stall_req_ready", req_ready, 0);
      tick();
    end
    ready_insert = 1'b1;
    #1;
    check("req_ready", req_ready, onehot);
    check("hdr_s_ready", s_ready_in, 0);
    tick();
    ready_insert = 1'b0;
    check("pay_no_hdr", valid_insert, 0);
    for (int b = 0; b < nbeats; b++) begin
      if (abort && b == 1) begin
        s_valid_in = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid_in", valid_in, 0);
        check("abort_pkt_cnt", pkt_cnt, 0);
        last_g  = NS - 1;
        exp_cnt = 0;
        quiet();
        return;
      end
      acc = 1'b0;
      for (int t = 0; t < 8 && !acc; t++) begin
        sv = (t >= 3) || !rnd || ($urandom_range(0, 2) != 0);
        rd = (t >= 3) || !rnd || ($urandom_range(0, 2) != 0);
        s_valid_in = sv;
        ready_in   = rd;
        s_last_in  = (b == nbeats - 1);
        last_out   = rnd ? 1'($urandom) : 1'b0;
        valid_out  = last_out;
        ready_out  = 1'b1;
        #1;
        check("pay_valid_in", valid_in, sv);
        check("pay_s_ready", s_ready_in, rd);
        check("pay_busy", busy, 1);
        acc = sv && rd;
        tick();
      end
    end
    s_valid_in = 1'b0;
    s_last_in  = 1'b0;
    ready_in   = 1'b1;
    last_out   = 1'b1;
    valid_out  = 1'b1;
    ready_out  = 1'b0;
    #1;
    check("drain_busy", busy, 1);
    check("drain_s_ready", s_ready_in, 0);
    check("drain_valid_insert", valid_insert, 0);
    tick();
    check("drain_hold_cnt", pkt_cnt, exp_cnt);
    ready_out = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) % 65536;
    last_g  = src;
    quiet();
    #1;
    check("done_busy", busy, 0);
    check("done_pkt_cnt", pkt_cnt, exp_cnt);
  endtask

  initial begin
    int g;
    int exp_seq [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NS; i++) begin
      hdr_d[i] = $urandom;
      hdr_k[i] = BW'($urandom);
      hdr_c[i] = CW'($urandom);
    end
    quiet();
    rst = 1'b1;
    tick();
    tick();
    do_reset();

    hdr_d[0] = 32'hAABBCCDD;
    hdr_k[0] = 4'b1111;
    hdr_c[0] = 2'd3;
    run_packet(4'b0001, 3, 0, 1'b0, 1'b0, g);
    check("s1_grant", g, 0);
    check("s1_pkt_cnt", pkt_cnt, 1);

    do_reset();
    for (int p = 0; p < 5; p++) begin
      run_packet(4'b1111, 2, 0, 1'b0, 1'b0, g);
      check("rr_seq", grant_id, exp_seq[p]);
    end

    run_packet(4'b0010, 2, 5, 1'b0, 1'b0, g);
    run_packet(4'b0100, 1, 0, 1'b0, 1'b0, g);

    last_out  = 1'b1;
    valid_out = 1'b1;
    ready_out = 1'b1;
    repeat (3) tick();
    check("stray_last_cnt", pkt_cnt, exp_cnt);
    check("stray_last_busy", busy, 0);
    quiet();

    do_reset();
    run_packet(4'b1000, 3, 0, 1'b0, 1'b1, g);
    run_packet(4'b1010, 1, 0, 1'b0, 1'b0, g);
    check("post_abort_grant", g, 1);

    for (int p = 0; p < 40; p++) begin
      run_packet(NS'($urandom_range(1, 15)), $urandom_range(1, 4),
                 $urandom_range(0, 3), 1'b1, 1'b0, g);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
